// File: rtl/lockin_frame_fifo.sv
// Lock-in output stage: stamps NUM_CH result words with a shared sequence number,
// decimates the tick stream and buffers whole frames in a first-word-fall-through FIFO.
module lockin_frame_fifo #(
  parameter int NUM_CH  = 2,
  parameter int DATA_W  = 24,
  parameter int SEQ_W   = 8,
  parameter int DEPTH   = 16,
  parameter int DECIM_W = 8,
  parameter int OVF_W   = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                tick_i,
  input  logic [NUM_CH*DATA_W-1:0]            data_i,
  input  logic [DECIM_W-1:0]                  decim_i,
  input  logic                                rd_i,
  output logic [NUM_CH*(SEQ_W+DATA_W)-1:0]    frame_o,
  output logic                                valid_o,
  output logic [$clog2(DEPTH):0]              level_o,
  output logic [OVF_W-1:0]                    ovf_cnt_o,
  output logic [SEQ_W-1:0]                    seq_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int WORD_W  = SEQ_W + DATA_W;
  localparam int FRAME_W = NUM_CH * WORD_W;

  logic [FRAME_W-1:0] mem [DEPTH];
  logic [PTR_W:0]     wr_ptr, rd_ptr, rd_next;
  logic [LVL_W-1:0]   level;
  logic [FRAME_W-1:0] head, new_frame;
  logic [SEQ_W-1:0]   seq;
  logic [DECIM_W-1:0] dcnt;
  logic [OVF_W-1:0]   ovf_cnt;
  logic               empty, full, keep, pop, push, drop;

  // Read side handshake: valid_o says frame_o holds the head frame; a one-cycle
  // rd_i while valid_o is high consumes it, rd_i while empty is silently ignored.
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
              (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    keep    = tick_i && (dcnt == '0);
    pop     = rd_i && !empty;
    push    = keep && (!full || pop);
    drop    = keep && full && !pop;
    rd_next = rd_ptr + {{PTR_W{1'b0}}, pop};
    new_frame = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      new_frame[c*WORD_W +: WORD_W] = {seq, data_i[c*DATA_W +: DATA_W]};
    end
  end

  // Frame storage carries no reset; the pointers alone decide what is live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= new_frame;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      head    <= '0;
      seq     <= '0;
      dcnt    <= '0;
      ovf_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + {{PTR_W{1'b0}}, 1'b1};
      rd_ptr <= rd_next;
      level  <= level + {{(LVL_W-1){1'b0}}, push} - {{(LVL_W-1){1'b0}}, pop};
      // Registered head: take the incoming frame when it lands in the slot being exposed.
      if (push && (wr_ptr == rd_next)) head <= new_frame;
      else                             head <= mem[rd_next[PTR_W-1:0]];
      if (tick_i) begin
        seq  <= seq + SEQ_W'(1);
        dcnt <= (dcnt >= decim_i) ? '0 : dcnt + DECIM_W'(1);
      end
      if (drop && (ovf_cnt != '1)) ovf_cnt <= ovf_cnt + OVF_W'(1);
    end
  end

  assign frame_o   = head;
  assign valid_o   = !empty;
  assign level_o   = level;
  assign ovf_cnt_o = ovf_cnt;
  assign seq_o     = seq;

endmodule

// File: tb/tb_lockin_frame_fifo.sv
// Bench for lockin_frame_fifo: directed scenarios plus randomized traffic checked
// against a queue-based model of the frame stream.
module tb_lockin_frame_fifo;

  localparam int NUM_CH  = 2;
  localparam int DATA_W  = 24;
  localparam int SEQ_W   = 8;
  localparam int DEPTH   = 16;
  localparam int DECIM_W = 8;
  localparam int OVF_W   = 16;
  localparam int WORD_W  = SEQ_W + DATA_W;
  localparam int FRAME_W = NUM_CH * WORD_W;
  localparam int LVL_W   = $clog2(DEPTH) + 1;
  localparam int OVF_MAX = (1 << OVF_W) - 1;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       tick_i;
  logic [NUM_CH*DATA_W-1:0]   data_i;
  logic [DECIM_W-1:0]         decim_i;
  logic                       rd_i;
  logic [FRAME_W-1:0]         frame_o;
  logic                       valid_o;
  logic [LVL_W-1:0]           level_o;
  logic [OVF_W-1:0]           ovf_cnt_o;
  logic [SEQ_W-1:0]           seq_o;

  lockin_frame_fifo #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .SEQ_W(SEQ_W),
    .DEPTH(DEPTH), .DECIM_W(DECIM_W), .OVF_W(OVF_W)
  ) dut (
    .clk(clk), .reset(reset), .tick_i(tick_i), .data_i(data_i),
    .decim_i(decim_i), .rd_i(rd_i), .frame_o(frame_o), .valid_o(valid_o),
    .level_o(level_o), .ovf_cnt_o(ovf_cnt_o), .seq_o(seq_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: frame queue plus tick/seq/drop bookkeeping
  logic [FRAME_W-1:0] exp_q[$];
  int                 m_ticks;
  logic [SEQ_W-1:0]   m_seq;
  int                 m_decim;
  int                 m_ovf;

  function automatic logic [FRAME_W-1:0] make_frame(input logic [SEQ_W-1:0] s,
                                                    input logic [NUM_CH*DATA_W-1:0] d);
    logic [FRAME_W-1:0] f;
    f = '0;
    for (int c = 0; c < NUM_CH; c++) f[c*WORD_W +: WORD_W] = {s, d[c*DATA_W +: DATA_W]};
    return f;
  endfunction

  function automatic logic [NUM_CH*DATA_W-1:0] rand_data();
    logic [NUM_CH*DATA_W-1:0] d;
    for (int c = 0; c < NUM_CH; c++) d[c*DATA_W +: DATA_W] = DATA_W'($urandom());
    return d;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_ticks = 0;
    m_seq   = '0;
    m_ovf   = 0;
  endtask

  task automatic set_decim(input int d);
    m_decim = d;
    decim_i = DECIM_W'(d);
  endtask

  // driver tasks
  task automatic do_reset(input logic with_tick);
    reset  = 1'b1;
    tick_i = with_tick;
    data_i = rand_data();
    rd_i   = with_tick;
    @(posedge clk); #1;
    reset  = 1'b0;
    tick_i = 1'b0;
    rd_i   = 1'b0;
    model_reset();
  endtask

  task automatic cycle(input logic t, input logic [NUM_CH*DATA_W-1:0] d, input logic r);
    bit kept, popped;
    tick_i = t;
    data_i = d;
    rd_i   = r;
    kept   = t && ((m_ticks % (m_decim + 1)) == 0);
    popped = r && (exp_q.size() > 0);
    if (popped) void'(exp_q.pop_front());
    if (kept) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(make_frame(m_seq, d));
      else if (m_ovf < OVF_MAX) m_ovf++;
    end
    if (t) begin
      m_ticks++;
      m_seq++;
    end
    @(posedge clk); #1;
    tick_i = 1'b0;
    rd_i   = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    do_reset(1'b0);
    checks++;
    if (level_o !== '0 || valid_o !== 1'b0 || frame_o !== '0 || ovf_cnt_o !== '0 || seq_o !== '0) begin
      errors++;
      $display("FAIL reset_state: level=%0d valid=%b frame=%h ovf=%0d seq=%0d, required all 0",
               level_o, valid_o, frame_o, ovf_cnt_o, seq_o);
    end
  endtask

  task automatic test_fill_drain();
    logic [63:0] exp_f [3];
    exp_f[0] = {32'h00FFFFFF, 32'h00000001};
    exp_f[1] = {32'h01FFFFFF, 32'h01000002};
    exp_f[2] = {32'h02FFFFFF, 32'h02000003};
    do_reset(1'b0);
    set_decim(0);
    for (int k = 1; k <= 3; k++) cycle(1'b1, {24'hFFFFFF, 24'(k)}, 1'b0);
    checks++;
    if (level_o !== LVL_W'(3)) begin
      errors++;
      $display("FAIL fill_level: got %0d, required 3", level_o);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (valid_o !== 1'b1 || frame_o !== FRAME_W'(exp_f[k])) begin
        errors++;
        $display("FAIL drain_frame%0d: valid=%b frame=%h, required valid=1 frame=%h",
                 k, valid_o, frame_o, exp_f[k]);
      end
      cycle(1'b0, '0, 1'b1);
    end
    checks++;
    if (valid_o !== 1'b0 || level_o !== '0) begin
      errors++;
      $display("FAIL drain_empty: valid=%b level=%0d, required 0/0", valid_o, level_o);
    end
  endtask

  task automatic test_decimation();
    int exp_seq [3] = '{0, 4, 8};
    do_reset(1'b0);
    set_decim(3);
    for (int k = 0; k < 10; k++) cycle(1'b1, rand_data(), 1'b0);
    checks++;
    if (level_o !== LVL_W'(3) || seq_o !== SEQ_W'(10)) begin
      errors++;
      $display("FAIL decim_counts: level=%0d seq=%0d, required level=3 seq=10", level_o, seq_o);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (frame_o[DATA_W +: SEQ_W] !== SEQ_W'(exp_seq[k]) || frame_o !== exp_q[0]) begin
        errors++;
        $display("FAIL decim_frame%0d: frame=%h, required %h (seq %0d)",
                 k, frame_o, exp_q[0], exp_seq[k]);
      end
      cycle(1'b0, '0, 1'b1);
    end
    set_decim(0);
  endtask

  task automatic test_overflow();
    do_reset(1'b0);
    set_decim(0);
    for (int k = 0; k < 20; k++) cycle(1'b1, rand_data(), 1'b0);
    checks++;
    if (level_o !== LVL_W'(16) || ovf_cnt_o !== OVF_W'(4) || valid_o !== 1'b1) begin
      errors++;
      $display("FAIL ovf_counts: level=%0d ovf=%0d valid=%b, required 16/4/1", level_o, ovf_cnt_o, valid_o);
    end
    checks++;
    if (frame_o[DATA_W +: SEQ_W] !== '0 || exp_q[DEPTH-1][DATA_W +: SEQ_W] !== SEQ_W'(15)
        || frame_o !== exp_q[0]) begin
      errors++;
      $display("FAIL ovf_head: frame=%h, required %h (head seq 0, tail seq 15)", frame_o, exp_q[0]);
    end
    cycle(1'b1, rand_data(), 1'b1);
    checks++;
    if (level_o !== LVL_W'(16) || ovf_cnt_o !== OVF_W'(4) || frame_o !== exp_q[0]) begin
      errors++;
      $display("FAIL full_rdwr: level=%0d ovf=%0d frame=%h, required 16/4/%h",
               level_o, ovf_cnt_o, frame_o, exp_q[0]);
    end
    while (exp_q.size() > 0) begin
      checks++;
      if (frame_o !== exp_q[0] || level_o !== LVL_W'(exp_q.size())) begin
        errors++;
        $display("FAIL ovf_drain: frame=%h level=%0d, required %h/%0d",
                 frame_o, level_o, exp_q[0], exp_q.size());
      end
      cycle(1'b0, '0, 1'b1);
    end
  endtask

  task automatic test_empty_cases();
    logic [NUM_CH*DATA_W-1:0] d;
    do_reset(1'b0);
    set_decim(0);
    cycle(1'b0, '0, 1'b1);
    checks++;
    if (level_o !== '0 || valid_o !== 1'b0 || ovf_cnt_o !== '0 || seq_o !== '0) begin
      errors++;
      $display("FAIL rd_empty: level=%0d valid=%b ovf=%0d seq=%0d, required all 0",
               level_o, valid_o, ovf_cnt_o, seq_o);
    end
    d = rand_data();
    cycle(1'b1, d, 1'b1);
    checks++;
    if (level_o !== LVL_W'(1) || valid_o !== 1'b1 || frame_o !== make_frame('0, d)) begin
      errors++;
      $display("FAIL rdwr_empty: level=%0d valid=%b frame=%h, required 1/1/%h",
               level_o, valid_o, frame_o, make_frame('0, d));
    end
  endtask

  task automatic test_seq_wrap();
    bit saw_wrap = 0;
    logic [SEQ_W-1:0] prev = '0;
    do_reset(1'b0);
    set_decim(0);
    for (int k = 0; k < 260; k++) begin
      cycle(1'b1, rand_data(), 1'b1);
      checks++;
      if (valid_o !== 1'b1 || level_o !== LVL_W'(1) || frame_o !== exp_q[0]) begin
        errors++;
        $display("FAIL wrap_cycle%0d: valid=%b level=%0d frame=%h, required 1/1/%h",
                 k, valid_o, level_o, frame_o, exp_q[0]);
      end
      if (k > 0 && prev == 8'hFF && frame_o[DATA_W +: SEQ_W] == '0) saw_wrap = 1;
      prev = frame_o[DATA_W +: SEQ_W];
    end
    checks++;
    if (!saw_wrap) begin
      errors++;
      $display("FAIL seq_wrap: seq 255 followed by 0 seen=%0d, required 1", saw_wrap);
    end
  endtask

  task automatic test_random();
    for (int pass = 0; pass < 3; pass++) begin
      do_reset(1'b0);
      set_decim($urandom_range(0, 3));
      for (int k = 0; k < 300; k++) begin
        cycle(1'($urandom_range(0, 99) < 70), rand_data(), 1'($urandom_range(0, 99) < 35 + pass * 20));
        checks++;
        if (level_o !== LVL_W'(exp_q.size()) || valid_o !== (exp_q.size() > 0) ||
            ovf_cnt_o !== OVF_W'(m_ovf) || seq_o !== m_seq ||
            (exp_q.size() > 0 && frame_o !== exp_q[0])) begin
          errors++;
          $display("FAIL random_p%0d_c%0d: level=%0d valid=%b ovf=%0d seq=%0d frame=%h, required %0d/%0d/%0d/%0d/%h",
                   pass, k, level_o, valid_o, ovf_cnt_o, seq_o, frame_o, exp_q.size(),
                   exp_q.size() > 0, m_ovf, m_seq, (exp_q.size() > 0) ? exp_q[0] : '0);
        end
      end
    end
    set_decim(0);
  endtask

  task automatic test_reset_mid();
    logic [NUM_CH*DATA_W-1:0] d;
    do_reset(1'b0);
    set_decim(0);
    for (int k = 0; k < 5; k++) cycle(1'b1, rand_data(), 1'b0);
    do_reset(1'b1);
    checks++;
    if (level_o !== '0 || valid_o !== 1'b0 || frame_o !== '0 || ovf_cnt_o !== '0 || seq_o !== '0) begin
      errors++;
      $display("FAIL reset_mid: level=%0d valid=%b frame=%h ovf=%0d seq=%0d, required all 0",
               level_o, valid_o, frame_o, ovf_cnt_o, seq_o);
    end
    d = rand_data();
    cycle(1'b1, d, 1'b0);
    checks++;
    if (level_o !== LVL_W'(1) || frame_o !== make_frame('0, d)) begin
      errors++;
      $display("FAIL post_reset_frame: level=%0d frame=%h, required 1/%h", level_o, frame_o, make_frame('0, d));
    end
  endtask

  initial begin
    reset   = 1'b1;
    tick_i  = 1'b0;
    rd_i    = 1'b0;
    data_i  = '0;
    set_decim(0);
    model_reset();
    test_reset();
    test_fill_drain();
    test_decimation();
    test_overflow();
    test_empty_cases();
    test_seq_wrap();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
